// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage sitting between the PC register and decode.
// Issues a req/ack read to instruction memory for the current pc, presents the
// fetched word to decode under a valid/ready handshake, computes the PC register's
// next value (hold, pc+INC, redirect target or reset vector) and counts accepted
// instructions.
//
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   pc                  - current PC from the PC register
//   pcNext              - next PC (combinational), loaded by the PC register
//   imem_req/addr       - memory read request and word-aligned address
//   imem_ack/rdata      - memory read acknowledge and instruction word
//   instr/instr_pc      - fetched instruction and its address
//   instr_valid         - instr/instr_pc valid towards decode
//   dec_ready           - decode accepts when instr_valid && dec_ready
//   redirect_valid/target - taken branch/jump, flushes the stage
//   fetch_count         - number of instructions accepted by decode
module fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned INC          = 4,
    parameter logic [31:0] NOP_INSTR    = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    output logic [31:0] pcNext,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        dec_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic [31:0] fetch_count
);

    localparam int unsigned XLEN = 32;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_ISSUE = 2'd2;
    localparam logic [1:0] S_FLUSH = 2'd3;

    logic [1:0]      r_state;
    logic [1:0]      w_state_next;
    logic            w_load;
    logic            w_accept;
    logic            w_flush;
    logic [XLEN-1:0] r_instr;
    logic [XLEN-1:0] r_instr_pc;
    logic [XLEN-1:0] r_fetch_count;

    // Target low bits are architecturally ignored (forced to zero).
    logic w_unused;
    assign w_unused = &{1'b0, redirect_target[1:0]};

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state, next PC and datapath strobes; reset overrides everything,
    // redirect overrides ack/ready.
    always_comb begin
        w_state_next = r_state;
        pcNext       = pc;
        w_load       = 1'b0;
        w_accept     = 1'b0;
        w_flush      = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_state_next = S_FETCH;
            end
            S_FETCH: begin
                if (redirect_valid) begin
                    w_flush = 1'b1;
                end else if (imem_ack) begin
                    w_load       = 1'b1;
                    pcNext       = pc + XLEN'(INC);
                    w_state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (redirect_valid) begin
                    w_flush = 1'b1;
                end else if (dec_ready) begin
                    w_accept     = 1'b1;
                    w_state_next = S_FETCH;
                end
            end
            default: begin
                if (redirect_valid) begin
                    w_flush = 1'b1;
                end else begin
                    w_state_next = S_FETCH;
                end
            end
        endcase

        if (w_flush) begin
            pcNext       = {redirect_target[XLEN-1:2], 2'b00};
            w_state_next = S_FLUSH;
        end

        if (reset) begin
            pcNext       = RESET_VECTOR;
            w_state_next = S_IDLE;
            w_load       = 1'b0;
            w_accept     = 1'b0;
            w_flush      = 1'b0;
        end
    end

    // Instruction hold registers and retired-fetch counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_instr       <= NOP_INSTR;
            r_instr_pc    <= '0;
            r_fetch_count <= '0;
        end else begin
            if (w_load) begin
                r_instr    <= imem_rdata;
                r_instr_pc <= pc;
            end
            if (w_flush) begin
                r_instr <= NOP_INSTR;
            end
            if (w_accept) begin
                r_fetch_count <= r_fetch_count + XLEN'(1);
            end
        end
    end

    // Handshake outputs are pure decodes of the state register.
    assign imem_req    = (r_state == S_FETCH);
    assign instr_valid = (r_state == S_ISSUE);
    assign imem_addr   = {pc[XLEN-1:2], 2'b00};
    assign instr       = r_instr;
    assign instr_pc    = r_instr_pc;
    assign fetch_count = r_fetch_count;

endmodule
